// File: rtl/sparc_exu_ccr_pkg.sv
// Shared types and helpers for the EXU per-thread CCR write-port scheduler.
package sparc_exu_ccr_pkg;

    localparam int NTHR  = 4;
    localparam int CCR_W = 8;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_DIV = 2'd1,
        SRC_TLU = 2'd2
    } ccr_src_e;

    function automatic logic [NTHR-1:0] tid_dec(input logic [1:0] tid);
        logic [NTHR-1:0] onehot;
        onehot      = '0;
        onehot[tid] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/sparc_exu_rr4_pick.sv
// 4-way round-robin first-set finder: first asserted req at or after ptr (mod 4).
module sparc_exu_rr4_pick
    import sparc_exu_ccr_pkg::*;
(
    input  logic [NTHR-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NTHR-1:0] gnt,
    output logic [1:0]      gnt_tid
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the slot closest to ptr is the last writer.
    always_comb begin
        gnt     = '0;
        gnt_tid = '0;
        idx     = '0;
        for (int i = NTHR - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                gnt     = tid_dec(idx);
                gnt_tid = idx;
            end
        end
    end

endmodule

// File: rtl/sparc_exu_ccrwr_sched.sv
// Shares the single CCR write port among TLU restore, divider and ALU writers,
// parking losers per thread and draining them round-robin with starvation relief.
module sparc_exu_ccrwr_sched
    import sparc_exu_ccr_pkg::*;
#(
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             alu_wr_vld_w,
    input  logic [1:0]       alu_wr_tid_w,
    input  logic [CCR_W-1:0] alu_wr_data_w,
    input  logic             div_wr_vld_w2,
    input  logic [1:0]       div_wr_tid_w2,
    input  logic [CCR_W-1:0] div_wr_data_w2,
    input  logic             tlu_wr_vld,
    input  logic [1:0]       tlu_wr_tid,
    input  logic [CCR_W-1:0] tlu_wr_data,
    input  logic [1:0]       tid_d,
    output logic [NTHR-1:0]  ccr_wen,
    output logic [CCR_W-1:0] ccr_wdata,
    output logic [NTHR-1:0]  pend_vld,
    output logic             ccr_stall_d
);

    logic [CCR_W-1:0] pend_data [NTHR];
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] starve_cnt;

    logic             div_surv, alu_surv, any_new;
    logic [NTHR-1:0]  new_mask, drain_req, pick_gnt;
    logic [1:0]       pick_tid;
    logic             force_drain, drain;
    ccr_src_e         grant_src;

    logic [NTHR-1:0]  wen_nxt;
    logic [CCR_W-1:0] wdata_nxt;
    logic [NTHR-1:0]  pend_vld_nxt;
    logic [CCR_W-1:0] pend_data_nxt [NTHR];
    logic [1:0]       rr_ptr_nxt;
    logic [CNT_W-1:0] starve_cnt_nxt;

    // A lower-priority writer to the same thread is older and simply dropped.
    assign div_surv = div_wr_vld_w2 && !(tlu_wr_vld && (tlu_wr_tid == div_wr_tid_w2));
    assign alu_surv = alu_wr_vld_w
                      && !(tlu_wr_vld && (tlu_wr_tid == alu_wr_tid_w))
                      && !(div_wr_vld_w2 && (div_wr_tid_w2 == alu_wr_tid_w));
    assign any_new  = tlu_wr_vld | div_surv | alu_surv;

    assign new_mask = (tlu_wr_vld ? tid_dec(tlu_wr_tid)    : '0)
                    | (div_surv   ? tid_dec(div_wr_tid_w2) : '0)
                    | (alu_surv   ? tid_dec(alu_wr_tid_w)  : '0);

    // With no new requests this equals pend_vld, so one picker serves both drain kinds.
    assign drain_req   = pend_vld & ~new_mask;
    assign force_drain = (starve_cnt == CNT_W'(STARVE_MAX)) && (|drain_req);
    assign drain       = force_drain || (!any_new && (|pend_vld));

    sparc_exu_rr4_pick u_pick (
        .req     (drain_req),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_tid (pick_tid)
    );

    always_comb begin
        wen_nxt       = '0;
        wdata_nxt     = ccr_wdata;
        pend_vld_nxt  = pend_vld;
        pend_data_nxt = pend_data;
        grant_src     = tlu_wr_vld ? SRC_TLU : (div_surv ? SRC_DIV : SRC_ALU);

        if (drain) begin
            wen_nxt                = pick_gnt;
            wdata_nxt              = pend_data[pick_tid];
            pend_vld_nxt[pick_tid] = 1'b0;
        end

        if (tlu_wr_vld) begin
            if (!drain && grant_src == SRC_TLU) begin
                wen_nxt                  = tid_dec(tlu_wr_tid);
                wdata_nxt                = tlu_wr_data;
                pend_vld_nxt[tlu_wr_tid] = 1'b0;
            end else begin
                pend_vld_nxt[tlu_wr_tid]  = 1'b1;
                pend_data_nxt[tlu_wr_tid] = tlu_wr_data;
            end
        end

        if (div_surv) begin
            if (!drain && grant_src == SRC_DIV) begin
                wen_nxt                     = tid_dec(div_wr_tid_w2);
                wdata_nxt                   = div_wr_data_w2;
                pend_vld_nxt[div_wr_tid_w2] = 1'b0;
            end else begin
                pend_vld_nxt[div_wr_tid_w2]  = 1'b1;
                pend_data_nxt[div_wr_tid_w2] = div_wr_data_w2;
            end
        end

        if (alu_surv) begin
            if (!drain && grant_src == SRC_ALU) begin
                wen_nxt                    = tid_dec(alu_wr_tid_w);
                wdata_nxt                  = alu_wr_data_w;
                pend_vld_nxt[alu_wr_tid_w] = 1'b0;
            end else begin
                pend_vld_nxt[alu_wr_tid_w]  = 1'b1;
                pend_data_nxt[alu_wr_tid_w] = alu_wr_data_w;
            end
        end

        rr_ptr_nxt = drain ? (pick_tid + 2'd1) : rr_ptr;

        if (drain || (pend_vld == '0))
            starve_cnt_nxt = '0;
        else if (starve_cnt != CNT_W'(STARVE_MAX))
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        else
            starve_cnt_nxt = starve_cnt;
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            ccr_wen    <= '0;
            ccr_wdata  <= '0;
            pend_vld   <= '0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            for (int t = 0; t < NTHR; t++)
                pend_data[t] <= '0;
        end else begin
            ccr_wen    <= wen_nxt;
            ccr_wdata  <= wdata_nxt;
            pend_vld   <= pend_vld_nxt;
            rr_ptr     <= rr_ptr_nxt;
            starve_cnt <= starve_cnt_nxt;
            for (int t = 0; t < NTHR; t++)
                pend_data[t] <= pend_data_nxt[t];
        end
    end

    assign ccr_stall_d = pend_vld[tid_d] | ccr_wen[tid_d];

endmodule

// File: tb/tb_sparc_exu_ccrwr_sched.sv
// Scoreboard bench for the CCR write-port scheduler: expected port writes are
// queued as each cycle's requests are driven and checked one edge later.
module tb_sparc_exu_ccrwr_sched;

    logic       clk = 1'b0;
    logic       arst_l;
    logic       alu_wr_vld_w, div_wr_vld_w2, tlu_wr_vld;
    logic [1:0] alu_wr_tid_w, div_wr_tid_w2, tlu_wr_tid, tid_d;
    logic [7:0] alu_wr_data_w, div_wr_data_w2, tlu_wr_data;
    logic [3:0] ccr_wen, pend_vld;
    logic [7:0] ccr_wdata;
    logic       ccr_stall_d;

    logic [11:0] exp_q [$];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sparc_exu_ccrwr_sched dut (
        .clk            (clk),
        .arst_l         (arst_l),
        .alu_wr_vld_w   (alu_wr_vld_w),
        .alu_wr_tid_w   (alu_wr_tid_w),
        .alu_wr_data_w  (alu_wr_data_w),
        .div_wr_vld_w2  (div_wr_vld_w2),
        .div_wr_tid_w2  (div_wr_tid_w2),
        .div_wr_data_w2 (div_wr_data_w2),
        .tlu_wr_vld     (tlu_wr_vld),
        .tlu_wr_tid     (tlu_wr_tid),
        .tlu_wr_data    (tlu_wr_data),
        .tid_d          (tid_d),
        .ccr_wen        (ccr_wen),
        .ccr_wdata      (ccr_wdata),
        .pend_vld       (pend_vld),
        .ccr_stall_d    (ccr_stall_d)
    );

    // Drive one cycle of requests, queue the expected port write, then
    // compare the registered port one edge later.
    task automatic step(input string name,
                        input logic tv, input logic [1:0] tt, input logic [7:0] td,
                        input logic dv, input logic [1:0] dt, input logic [7:0] dd,
                        input logic av, input logic [1:0] at, input logic [7:0] ad,
                        input logic [3:0] ew, input logic [7:0] ed);
        logic [11:0] e;
        tlu_wr_vld = tv;    tlu_wr_tid = tt;    tlu_wr_data = td;
        div_wr_vld_w2 = dv; div_wr_tid_w2 = dt; div_wr_data_w2 = dd;
        alu_wr_vld_w = av;  alu_wr_tid_w = at;  alu_wr_data_w = ad;
        exp_q.push_back({ew, ed});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        nvec++;
        if (ccr_wen !== e[11:8]) begin
            nerr++;
            $display("FAIL %s ccr_wen: got %b want %b", name, ccr_wen, e[11:8]);
        end
        if (e[11:8] != 4'b0000) begin
            nvec++;
            if (ccr_wdata !== e[7:0]) begin
                nerr++;
                $display("FAIL %s ccr_wdata: got %h want %h", name, ccr_wdata, e[7:0]);
            end
        end
    endtask

    task automatic idle(input string name, input logic [3:0] ew, input logic [7:0] ed);
        step(name, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, ew, ed);
    endtask

    task automatic test_reset();
        nvec++;
        if (ccr_wen !== 4'b0000) begin nerr++; $display("FAIL reset_wen: got %b want 0000", ccr_wen); end
        nvec++;
        if (ccr_wdata !== 8'h00) begin nerr++; $display("FAIL reset_wdata: got %h want 00", ccr_wdata); end
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL reset_pend: got %b want 0000", pend_vld); end
        nvec++;
        if (ccr_stall_d !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", ccr_stall_d); end
    endtask

    task automatic test_single();
        step("single", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd2, 8'h5A, 4'b0100, 8'h5A);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL single_pend: got %b want 0000", pend_vld); end
        idle("single_idle", 4'b0000, 8'h00);
    endtask

    task automatic test_three_way();
        step("three_way", 1, 2'd0, 8'h11, 1, 2'd1, 8'h22, 1, 2'd3, 8'h33, 4'b0001, 8'h11);
        nvec++;
        if (pend_vld !== 4'b1010) begin nerr++; $display("FAIL three_way_pend: got %b want 1010", pend_vld); end
        tid_d = 2'd3;
        #1;
        nvec++;
        if (ccr_stall_d !== 1'b1) begin nerr++; $display("FAIL three_way_stall: got %b want 1", ccr_stall_d); end
        tid_d = 2'd0;
        idle("three_way_drain1", 4'b0010, 8'h22);
        idle("three_way_drain3", 4'b1000, 8'h33);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL three_way_pend_end: got %b want 0000", pend_vld); end
        idle("three_way_idle", 4'b0000, 8'h00);
    endtask

    task automatic test_collision();
        step("collision", 0, 2'd0, 8'h00, 1, 2'd1, 8'hAA, 1, 2'd1, 8'hBB, 4'b0010, 8'hAA);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL collision_pend: got %b want 0000", pend_vld); end
        idle("collision_idle", 4'b0000, 8'h00);
    endtask

    task automatic test_supersede();
        step("supersede_park", 1, 2'd0, 8'hF0, 0, 2'd0, 8'h00, 1, 2'd2, 8'h01, 4'b0001, 8'hF0);
        nvec++;
        if (pend_vld !== 4'b0100) begin nerr++; $display("FAIL supersede_pend: got %b want 0100", pend_vld); end
        step("supersede_new", 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd2, 8'h02, 4'b0100, 8'h02);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL supersede_clear: got %b want 0000", pend_vld); end
        idle("supersede_idle", 4'b0000, 8'h00);
    endtask

    task automatic test_starve();
        step("starve_park", 1, 2'd0, 8'hC0, 0, 2'd0, 8'h00, 1, 2'd3, 8'h3C, 4'b0001, 8'hC0);
        for (int k = 1; k <= 7; k++) begin
            step("starve_hold", 1, 2'd0, 8'hC0 + 8'(k), 0, 2'd0, 8'h00, 0, 2'd0, 8'h00,
                 4'b0001, 8'hC0 + 8'(k));
            nvec++;
            if (pend_vld !== 4'b1000) begin
                nerr++;
                $display("FAIL starve_hold_pend[%0d]: got %b want 1000", k, pend_vld);
            end
        end
        step("starve_force", 1, 2'd0, 8'hC8, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 4'b1000, 8'h3C);
        nvec++;
        if (pend_vld !== 4'b0001) begin nerr++; $display("FAIL starve_force_pend: got %b want 0001", pend_vld); end
        idle("starve_drain_t0", 4'b0001, 8'hC8);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL starve_end_pend: got %b want 0000", pend_vld); end
    endtask

    task automatic test_stall_reset();
        step("stall_setup", 1, 2'd0, 8'hE0, 1, 2'd1, 8'hE1, 0, 2'd0, 8'h00, 4'b0001, 8'hE0);
        tlu_wr_vld = 0; div_wr_vld_w2 = 0; alu_wr_vld_w = 0;
        tid_d = 2'd1;
        #1;
        nvec++;
        if (ccr_stall_d !== 1'b1) begin nerr++; $display("FAIL stall_pend: got %b want 1", ccr_stall_d); end
        tid_d = 2'd0;
        #1;
        nvec++;
        if (ccr_stall_d !== 1'b1) begin nerr++; $display("FAIL stall_wen: got %b want 1", ccr_stall_d); end
        tid_d = 2'd2;
        #1;
        nvec++;
        if (ccr_stall_d !== 1'b0) begin nerr++; $display("FAIL stall_none: got %b want 0", ccr_stall_d); end
        tid_d = 2'd1;
        arst_l = 1'b0;
        #1;
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL midreset_pend: got %b want 0000", pend_vld); end
        nvec++;
        if (ccr_wen !== 4'b0000) begin nerr++; $display("FAIL midreset_wen: got %b want 0000", ccr_wen); end
        nvec++;
        if (ccr_stall_d !== 1'b0) begin nerr++; $display("FAIL midreset_stall: got %b want 0", ccr_stall_d); end
        @(negedge clk);
        arst_l = 1'b1;
        idle("post_reset_idle", 4'b0000, 8'h00);
        nvec++;
        if (pend_vld !== 4'b0000) begin nerr++; $display("FAIL post_reset_pend: got %b want 0000", pend_vld); end
    endtask

    initial begin
        arst_l = 1'b0;
        tlu_wr_vld = 0; tlu_wr_tid = 0; tlu_wr_data = 0;
        div_wr_vld_w2 = 0; div_wr_tid_w2 = 0; div_wr_data_w2 = 0;
        alu_wr_vld_w = 0; alu_wr_tid_w = 0; alu_wr_data_w = 0;
        tid_d = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        arst_l = 1'b1;
        test_single();
        test_three_way();
        test_collision();
        test_supersede();
        test_starve();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
